shift_issue_arbiter: RTL and testbench

- Shares one 32-bit combinational barrel shifter between the two issue lanes of the dual-issue integer pipeline.
- Arbitrates same-cycle shift requests round-robin, using per-lane valid/ready handshakes.
- Decodes the op into the shifter's sra/sll controls and registers the result with its tag into a single output stage with backpressure.
- Supports pipeline flush and keeps a saturating backpressure-stall counter for performance monitoring.

---
 rtl/shift_issue_arbiter_pkg.sv | 23 ++
 rtl/Shifter.sv | 22 ++
 rtl/shift_issue_arbiter.sv | 131 +++++++++++++
 tb/tb_shift_issue_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_issue_arbiter_pkg.sv
// Shared types for the shift issue arbiter: shift-op encoding, datapath width
// and the per-lane request bundle.
package shift_issue_arbiter_pkg;

    localparam int SHIFT_XLEN = 32;
    localparam int SHAMT_W    = 5;
    localparam int REQ_TAG_W  = 6;

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SLL = 2'b01,
        OP_SRA = 2'b10,
        OP_ILL = 2'b11
    } shift_op_e;

    typedef struct packed {
        shift_op_e               op;
        logic [SHIFT_XLEN-1:0]   a;
        logic [SHIFT_XLEN-1:0]   b;
        logic [REQ_TAG_W-1:0]    tag;
    } shift_req_t;

endpackage

// File: rtl/Shifter.sv
// Combinational 32-bit barrel shifter; sll takes priority over sra,
// neither set means logical right shift.
module Shifter
    import shift_issue_arbiter_pkg::*;
(
    input  logic                  sra,
    input  logic                  sll,
    input  logic [SHAMT_W-1:0]    size,
    input  logic [SHIFT_XLEN-1:0] in,
    output logic [SHIFT_XLEN-1:0] out
);

    always_comb begin
        if (sll)
            out = in << size;
        else if (sra)
            out = $unsigned($signed(in) >>> size);
        else
            out = in >> size;
    end

endmodule

// File: rtl/shift_issue_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between two issue lanes,
// with a single registered output stage, flush and a saturating stall counter.
module shift_issue_arbiter
    import shift_issue_arbiter_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_op0,
    input  logic [1:0]        req_op1,
    input  logic [XLEN-1:0]   req_a0,
    input  logic [XLEN-1:0]   req_a1,
    input  logic [XLEN-1:0]   req_b0,
    input  logic [XLEN-1:0]   req_b1,
    input  logic [TAG_W-1:0]  req_tag0,
    input  logic [TAG_W-1:0]  req_tag1,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [XLEN-1:0]   res_data,
    output logic [TAG_W-1:0]  res_tag,
    output logic              res_lane,
    output logic              res_illegal,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    generate
        if (XLEN != SHIFT_XLEN) begin : g_bad_xlen
            $error("shift_issue_arbiter: XLEN must be 32");
        end
        if (TAG_W != REQ_TAG_W) begin : g_bad_tag_w
            $error("shift_issue_arbiter: TAG_W must match REQ_TAG_W");
        end
    endgenerate

    logic                r_res_valid;
    logic [XLEN-1:0]     r_res_data;
    logic [TAG_W-1:0]    r_res_tag;
    logic                r_res_lane;
    logic                r_res_illegal;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic                r_ptr;

    logic                w_slot_free;
    logic [1:0]          w_grant;
    logic                w_accept;
    shift_req_t          w_req0;
    shift_req_t          w_req1;
    shift_req_t          w_sel;
    logic                w_sra;
    logic                w_sll;
    logic [XLEN-1:0]     w_shift_out;
    logic                w_unused_b;

    assign w_slot_free = !r_res_valid || res_ready;

    // With both lanes valid the pointer picks; the pointer only moves on an
    // accept, so a waiting lane keeps its grant through backpressure.
    assign w_grant[0] = req_valid[0] && (!req_valid[1] || !r_ptr);
    assign w_grant[1] = req_valid[1] && (!req_valid[0] ||  r_ptr);

    assign req_ready = (w_slot_free && !flush && !rst) ? w_grant : 2'b00;
    assign w_accept  = |(req_valid & req_ready);

    assign w_req0 = '{op: shift_op_e'(req_op0), a: req_a0, b: req_b0, tag: req_tag0};
    assign w_req1 = '{op: shift_op_e'(req_op1), a: req_a1, b: req_b1, tag: req_tag1};
    assign w_sel  = w_grant[1] ? w_req1 : w_req0;

    always_comb begin
        w_sra = 1'b0;
        w_sll = 1'b0;
        case (w_sel.op)
            OP_SLL:  w_sll = 1'b1;
            OP_SRA:  w_sra = 1'b1;
            default: ;
        endcase
    end

    assign w_unused_b = ^w_sel.b[XLEN-1:SHAMT_W];

    Shifter u_shifter (
        .sra  (w_sra),
        .sll  (w_sll),
        .size (w_sel.b[SHAMT_W-1:0]),
        .in   (w_sel.a),
        .out  (w_shift_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_tag     <= '0;
            r_res_lane    <= 1'b0;
            r_res_illegal <= 1'b0;
            r_stall_cnt   <= '0;
            r_ptr         <= 1'b0;
        end else begin
            if (w_accept)
                r_ptr <= ~w_grant[1];

            if (flush) begin
                r_res_valid <= 1'b0;
            end else if (w_accept) begin
                r_res_valid   <= 1'b1;
                r_res_data    <= w_shift_out;
                r_res_tag     <= w_sel.tag;
                r_res_lane    <= w_grant[1];
                r_res_illegal <= (w_sel.op == OP_ILL);
            end else if (res_ready) begin
                r_res_valid <= 1'b0;
            end

            if (r_res_valid && !res_ready && !flush && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_tag     = r_res_tag;
    assign res_lane    = r_res_lane;
    assign res_illegal = r_res_illegal;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_shift_issue_arbiter.sv
// Bench for shift_issue_arbiter: a negedge reference model predicts req_ready
// and queues expected results; directed scenarios add fixed-value checks.
module tb_shift_issue_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  req_op0 = 2'b00, req_op1 = 2'b00;
    logic [31:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
    logic [5:0]  req_tag0 = '0, req_tag1 = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;
    logic [5:0]  res_tag;
    logic        res_lane;
    logic        res_illegal;
    logic        flush = 1'b0;
    logic [15:0] stall_cnt;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  tag;
        logic        lane;
        logic        ill;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic        m_vld = 1'b0;
    logic        m_ptr = 1'b0;
    logic [15:0] m_cnt = '0;

    shift_issue_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_a1(req_a1),
        .req_b0(req_b0), .req_b1(req_b1),
        .req_tag0(req_tag0), .req_tag1(req_tag1),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag),
        .res_lane(res_lane), .res_illegal(res_illegal),
        .flush(flush), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [4:0] amt;
        amt = b[4:0];
        case (op)
            2'b01:   ref_shift = a << amt;
            2'b10:   ref_shift = $unsigned($signed(a) >>> amt);
            default: ref_shift = a >> amt;
        endcase
    endfunction

    // Reference model: evaluated mid-cycle with the inputs that the next edge sees.
    always @(negedge clk) begin
        logic [1:0] g, er;
        logic       free;
        exp_t       e, x;
        free = !m_vld || res_ready;
        g[0] = req_valid[0] && (!req_valid[1] || !m_ptr);
        g[1] = req_valid[1] && (!req_valid[0] ||  m_ptr);
        er   = (rst || flush || !free) ? 2'b00 : g;
        check("req_ready", 64'(req_ready), 64'(er));
        check("res_valid", 64'(res_valid), 64'(m_vld));
        check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        if (m_vld && res_ready && !flush && !rst) begin
            check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                x = sb_q.pop_front();
                check("res_data", 64'(res_data), 64'(x.data));
                check("res_tag", 64'(res_tag), 64'(x.tag));
                check("res_lane", 64'(res_lane), 64'(x.lane));
                check("res_illegal", 64'(res_illegal), 64'(x.ill));
            end
        end
        if (rst) begin
            sb_q.delete();
            m_vld = 1'b0;
            m_ptr = 1'b0;
            m_cnt = '0;
        end else begin
            if (m_vld && !res_ready && !flush && m_cnt != 16'hFFFF)
                m_cnt = m_cnt + 16'd1;
            if (flush) begin
                if (m_vld && sb_q.size() != 0)
                    void'(sb_q.pop_front());
                m_vld = 1'b0;
            end else begin
                if (m_vld && res_ready)
                    m_vld = 1'b0;
                if (er != 2'b00) begin
                    e.lane = er[1];
                    e.data = er[1] ? ref_shift(req_op1, req_a1, req_b1)
                                   : ref_shift(req_op0, req_a0, req_b0);
                    e.tag  = er[1] ? req_tag1 : req_tag0;
                    e.ill  = er[1] ? (req_op1 == 2'b11) : (req_op0 == 2'b11);
                    sb_q.push_back(e);
                    m_vld = 1'b1;
                    m_ptr = ~er[1];
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 2'b00; flush = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic set0(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] tag);
        req_op0 = op; req_a0 = a; req_b0 = b; req_tag0 = tag;
    endtask

    task automatic set1(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] tag);
        req_op1 = op; req_a1 = a; req_b1 = b; req_tag1 = tag;
    endtask

    initial begin
        // Reset values, with both lanes requesting during reset
        req_valid = 2'b11;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check("rst_res_tag", 64'(res_tag), 64'd0);
        check("rst_res_lane", 64'(res_lane), 64'd0);
        check("rst_res_illegal", 64'(res_illegal), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);

        // Single request
        do_reset();
        set0(2'b00, 32'h8000_0000, 32'd4, 6'd5);
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        check("single_valid", 64'(res_valid), 64'd1);
        check("single_data", 64'(res_data), 64'h0800_0000);
        check("single_lane", 64'(res_lane), 64'd0);
        check("single_ill", 64'(res_illegal), 64'd0);
        check("single_tag", 64'(res_tag), 64'd5);

        // Dual contention: grants alternate from reset
        do_reset();
        set0(2'b10, 32'h8000_0000, 32'd31, 6'd10);
        set1(2'b01, 32'h0000_0001, 32'd31, 6'd11);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("dual_lane", 64'(res_lane), 64'(i % 2));
            check("dual_data", 64'(res_data), (i % 2 == 0) ? 64'hFFFF_FFFF : 64'h8000_0000);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;

        // Backpressure, then release with a same-cycle accept
        do_reset();
        set0(2'b01, 32'h0000_0003, 32'd2, 6'd9);
        set1(2'b00, 32'h0000_0100, 32'd8, 6'd12);
        req_valid = 2'b01;
        res_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_data_stable", 64'(res_data), 64'h0000_000C);
            @(posedge clk);
        end
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_stall_cnt", 64'(stall_cnt), 64'd5);
        check("bp_release_ready", 64'(req_ready), 64'b10);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        check("bp_nobubble_valid", 64'(res_valid), 64'd1);
        check("bp_nobubble_lane", 64'(res_lane), 64'd1);
        check("bp_nobubble_data", 64'(res_data), 64'h0000_0001);

        // Flush while a result is held and lane1 waits
        do_reset();
        set0(2'b00, 32'h0000_00F0, 32'd4, 6'd20);
        req_valid = 2'b01;
        res_ready = 1'b0;
        @(posedge clk); #1;
        set0(2'b01, 32'h0000_0001, 32'd1, 6'd21);
        set1(2'b10, 32'hF000_0000, 32'd4, 6'd22);
        req_valid = 2'b11;
        flush = 1'b1;
        @(negedge clk);
        check("flush_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check("flush_res_valid", 64'(res_valid), 64'd0);
        check("flush_ptr_kept", 64'(req_ready), 64'b10);
        @(posedge clk); #1;
        req_valid = 2'b01;
        @(negedge clk);
        check("flush_after_lane", 64'(res_lane), 64'd1);
        check("flush_after_data", 64'(res_data), 64'hFF00_0000);
        @(posedge clk); #1;
        req_valid = 2'b00;

        // Illegal op and zero shift amounts
        do_reset();
        set0(2'b11, 32'h0000_00F0, 32'h0000_0024, 6'd1);
        req_valid = 2'b01;
        @(posedge clk); #1;
        set0(2'b01, 32'hDEAD_BEEF, 32'd0, 6'd2);
        @(negedge clk);
        check("ill_data", 64'(res_data), 64'h0000_000F);
        check("ill_flag", 64'(res_illegal), 64'd1);
        @(posedge clk); #1;
        set0(2'b10, 32'h8000_0001, 32'h0000_0020, 6'd3);
        @(negedge clk);
        check("sll0_data", 64'(res_data), 64'hDEAD_BEEF);
        check("sll0_flag", 64'(res_illegal), 64'd0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        check("sra0_data", 64'(res_data), 64'h8000_0001);

        // Reset while a result is stalled
        do_reset();
        set0(2'b00, 32'h0000_0055, 32'd1, 6'd33);
        req_valid = 2'b01;
        res_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (7) @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_stall_cnt", 64'(stall_cnt), 64'd7);
        check("mid_res_valid", 64'(res_valid), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        set1(2'b01, 32'h0000_0001, 32'd4, 6'd34);
        req_valid = 2'b11;
        @(negedge clk);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid", 64'(res_valid), 64'd0);
        check("mid_rst_data", 64'(res_data), 64'd0);
        check("mid_rst_tag", 64'(res_tag), 64'd0);
        check("mid_rst_lane", 64'(res_lane), 64'd0);
        check("mid_rst_ill", 64'(res_illegal), 64'd0);
        check("mid_rst_cnt", 64'(stall_cnt), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        check("mid_ptr_reset_lane", 64'(res_lane), 64'd0);
        check("mid_ptr_reset_data", 64'(res_data), 64'h0000_002A);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
